// File: rtl/rtc_bus_ciclo_if.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_ciclo_if
//  Description : Signal bundle between the read-sequence FSM / RTC pad and
//                the rtc_bus_ciclo bus-cycle generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rtc_bus_ciclo_if;
  logic [4:0] ctrl_L;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       A_D;
  logic       Final_WR;
  logic [7:0] dato_leido;
  logic [3:0] reg_idx;
  logic       dato_valido;

  // Side that sequences steps and models the pad.
  modport master (
    output ctrl_L, ad_in,
    input  ad_out, ad_oe, CS_n, RD_n, WR_n, A_D,
    input  Final_WR, dato_leido, reg_idx, dato_valido
  );

  // Bus-cycle generator side.
  modport slave (
    input  ctrl_L, ad_in,
    output ad_out, ad_oe, CS_n, RD_n, WR_n, A_D,
    output Final_WR, dato_leido, reg_idx, dato_valido
  );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_ciclo.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_ciclo
//  Description : Runs one timed cycle on the RTC multiplexed address/data bus
//                per new step index: address write on odd steps, data read on
//                even steps. Returns a one-cycle Final_WR pulse and presents
//                read bytes with their register index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_ciclo #(
  parameter logic [7:0] ADDR_BASE = 8'h21,
  parameter int         T_SETUP   = 2,
  parameter int         T_PULSO   = 4,
  parameter int         T_HOLD    = 2
) (
  input  wire                  clk,
  input  wire                  reset,
  rtc_bus_ciclo_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    FIN    = 3'd4
  } state_t;

  // Phase reload values; each phase counts down to zero.
  localparam logic [2:0] C_LOAD_SETUP = 3'(T_SETUP - 1);
  localparam logic [2:0] C_LOAD_PULSO = 3'(T_PULSO - 1);
  localparam logic [2:0] C_LOAD_HOLD  = 3'(T_HOLD - 1);

  // Current state and registered outputs
  state_t     state;
  logic [2:0] cnt;
  logic [4:0] ctrl_prev;
  logic       rd_step;
  logic [3:0] pair;
  logic [7:0] rd_hold;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;
  logic       ad_oe;
  logic [7:0] ad_out;
  logic       final_wr;
  logic [7:0] dato_leido;
  logic [3:0] reg_idx;
  logic       dato_valido;

  // Next-state values
  state_t     state_nx;
  logic [2:0] cnt_nx;
  logic [4:0] ctrl_prev_nx;
  logic       rd_step_nx;
  logic [3:0] pair_nx;
  logic [7:0] rd_hold_nx;
  logic       cs_n_nx;
  logic       rd_n_nx;
  logic       wr_n_nx;
  logic       a_d_nx;
  logic       ad_oe_nx;
  logic [7:0] ad_out_nx;
  logic       final_wr_nx;
  logic [7:0] dato_leido_nx;
  logic [3:0] reg_idx_nx;
  logic       dato_valido_nx;

  // Launch decode of the incoming step index
  logic       launch;
  logic [3:0] launch_pair;
  logic       launch_rd;

  assign launch      = (bus.ctrl_L != ctrl_prev) &&
                       (bus.ctrl_L >= 5'd1) && (bus.ctrl_L <= 5'd20);
  assign launch_pair = 4'((bus.ctrl_L - 5'd1) >> 1);
  assign launch_rd   = ~bus.ctrl_L[0];

  // State and output register; reset aborts any cycle in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      ctrl_prev   <= 5'd0;
      rd_step     <= 1'b0;
      pair        <= 4'd0;
      rd_hold     <= 8'd0;
      cs_n        <= 1'b1;
      rd_n        <= 1'b1;
      wr_n        <= 1'b1;
      a_d         <= 1'b1;
      ad_oe       <= 1'b0;
      ad_out      <= 8'd0;
      final_wr    <= 1'b0;
      dato_leido  <= 8'd0;
      reg_idx     <= 4'd0;
      dato_valido <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ctrl_prev   <= ctrl_prev_nx;
      rd_step     <= rd_step_nx;
      pair        <= pair_nx;
      rd_hold     <= rd_hold_nx;
      cs_n        <= cs_n_nx;
      rd_n        <= rd_n_nx;
      wr_n        <= wr_n_nx;
      a_d         <= a_d_nx;
      ad_oe       <= ad_oe_nx;
      ad_out      <= ad_out_nx;
      final_wr    <= final_wr_nx;
      dato_leido  <= dato_leido_nx;
      reg_idx     <= reg_idx_nx;
      dato_valido <= dato_valido_nx;
    end
  end

  // Next-state and next-output logic; pulses default low, the rest hold
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    ctrl_prev_nx   = ctrl_prev;
    rd_step_nx     = rd_step;
    pair_nx        = pair;
    rd_hold_nx     = rd_hold;
    cs_n_nx        = cs_n;
    rd_n_nx        = rd_n;
    wr_n_nx        = wr_n;
    a_d_nx         = a_d;
    ad_oe_nx       = ad_oe;
    ad_out_nx      = ad_out;
    final_wr_nx    = 1'b0;
    dato_leido_nx  = dato_leido;
    reg_idx_nx     = reg_idx;
    dato_valido_nx = 1'b0;

    case (state)
      IDLE: begin
        // Out-of-range indices only refresh the history, so tracking the
        // input unconditionally here is exactly the required behaviour.
        ctrl_prev_nx = bus.ctrl_L;
        if (launch) begin
          state_nx   = SETUP;
          cnt_nx     = C_LOAD_SETUP;
          rd_step_nx = launch_rd;
          pair_nx    = launch_pair;
          cs_n_nx    = 1'b0;
          a_d_nx     = launch_rd;
          ad_oe_nx   = ~launch_rd;
          if (!launch_rd) begin
            ad_out_nx = ADDR_BASE + {4'd0, launch_pair};
          end
        end
      end

      SETUP: begin
        if (cnt == 3'd0) begin
          state_nx = STROBE;
          cnt_nx   = C_LOAD_PULSO;
          if (rd_step) begin
            rd_n_nx = 1'b0;
          end else begin
            wr_n_nx = 1'b0;
          end
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end

      STROBE: begin
        if (cnt == 3'd0) begin
          state_nx = HOLD;
          cnt_nx   = C_LOAD_HOLD;
          rd_n_nx  = 1'b1;
          wr_n_nx  = 1'b1;
          // Capture on the edge where RD_n rises: data is valid from the RTC.
          if (rd_step) begin
            rd_hold_nx = bus.ad_in;
          end
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end

      HOLD: begin
        if (cnt == 3'd0) begin
          state_nx    = FIN;
          cnt_nx      = 3'd0;
          final_wr_nx = 1'b1;
          cs_n_nx     = 1'b1;
          ad_oe_nx    = 1'b0;
          a_d_nx      = 1'b1;
          if (rd_step) begin
            dato_leido_nx  = rd_hold;
            reg_idx_nx     = pair;
            dato_valido_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end

      FIN: begin
        // Single-cycle state: guarantees Final_WR never lasts two cycles.
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.ad_out      = ad_out;
  assign bus.ad_oe       = ad_oe;
  assign bus.CS_n        = cs_n;
  assign bus.RD_n        = rd_n;
  assign bus.WR_n        = wr_n;
  assign bus.A_D         = a_d;
  assign bus.Final_WR    = final_wr;
  assign bus.dato_leido  = dato_leido;
  assign bus.reg_idx     = reg_idx;
  assign bus.dato_valido = dato_valido;

endmodule
`default_nettype wire

// File: doc/rtc_bus_ciclo.md
# rtc_bus_ciclo

Bus-cycle generator directly downstream of the read-sequence FSM. For each new step index on `ctrl_L`, it runs one timed cycle on the RTC multiplexed address/data bus: an address write on odd steps, a data read on even steps. It returns a one-cycle `Final_WR` pulse that advances the FSM. Read bytes are presented with a register index and a valid strobe for the register-bank stage that follows.

## Interface
- `ADDR_BASE`, 8'h21: RTC address of the first register in the read sequence.
- `T_SETUP`, 2: cycles from CS_n low to strobe low (≥1).
- `T_PULSO`, 4: strobe-low width in cycles (≥1).
- `T_HOLD`, 2: cycles from strobe high to CS_n high (≥1).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `ctrl_L`  in  5  step index from the read FSM (0 idle, 1..20 bus steps, 21 end marker).
- `ad_in`  in  8  bus data in from the pad.
- `ad_out`  out  8  bus data out to the pad.
- `ad_oe`  out  1  pad output enable (1 = drive `ad_out`).
- `CS_n`  out  1  chip select, active low.
- `RD_n`  out  1  read strobe, active low.
- `WR_n`  out  1  write strobe, active low.
- `A_D`  out  1  0 = address phase, 1 = data phase.
- `Final_WR`  out  1  one-cycle pulse marking the end of a bus cycle.
- `dato_leido`  out  8  last byte read.
- `reg_idx`  out  4  register index 0..9 of `dato_leido`.
- `dato_valido`  out  1  one-cycle pulse, coincident with `Final_WR` on read steps.

## Operation
- Outputs are registered.
- Reset values:
  - `CS_n=RD_n=WR_n=1`, `A_D=1`, `ad_oe=0`, `ad_out=0`.
  - `Final_WR=0`, `dato_leido=0`, `reg_idx=0`, `dato_valido=0`.
  - Internal state: `ctrl_prev=0`, state IDLE, counter 0.
- Step decode for step index s:
  - Pair p = (s-1)>>1.
  - Odd s: address write of `ADDR_BASE+p`, with `A_D=0`, `WR_n` strobe, `ad_oe=1`.
  - Even s: data read, with `A_D=1`, `RD_n` strobe, `ad_oe=0`.
- Launch condition, evaluated only in IDLE: `ctrl_L != ctrl_prev` and 1 ≤ `ctrl_L` ≤ 20. On launch, `ctrl_prev <= ctrl_L`.
- Index values 0, 21 and 22..31:
  - They update `ctrl_prev`.
  - They launch nothing and raise no error.
- States:
  - IDLE: waits for the launch condition, then goes to SETUP.
  - SETUP: `CS_n=0`; `A_D` and `ad_oe`/`ad_out` set per step; lasts T_SETUP cycles.
  - STROBE: `RD_n` or `WR_n` low; lasts T_PULSO cycles.
  - HOLD: strobe high, `CS_n` still 0, bus still driven on writes; lasts T_HOLD cycles.
  - FIN: `Final_WR=1` for one cycle; `CS_n=1`, `ad_oe=0`, `A_D=1`; returns to IDLE.
- Read capture: `ad_in` is sampled into a holding register on the last STROBE cycle, i.e. the edge on which `RD_n` rises.
  - `dato_leido` and `reg_idx=p` load on entry to FIN.
  - `dato_valido` is high in FIN on read steps only.
- `ctrl_L` changes while not in IDLE are ignored. The comparison uses the value present on return to IDLE, so a change made mid-cycle still launches afterwards.
- Phase counter: 3 bits wide, reloaded at each phase entry. No overflow is possible for parameters ≤ 8.
- Reset during a cycle aborts it immediately:
  - Strobes and `CS_n` go high asynchronously.
  - No `Final_WR` is issued.
  - Next state is IDLE with `ctrl_prev=0`.

## Timing
- Launch edge: the edge on which IDLE sees the launch condition. `CS_n` goes low at this edge.
- Strobe low at launch edge + T_SETUP.
- Strobe high at + T_SETUP+T_PULSO.
- `Final_WR` high at + T_SETUP+T_PULSO+T_HOLD for exactly one cycle. With defaults this is edge +8; `CS_n` high from the same edge.
- `Final_WR` is never high for two consecutive cycles. The FSM's registered output lags its state by one cycle, so a longer pulse would skip a step.
- The FSM presents the next index 2 cycles after the `Final_WR` edge. IDLE relaunches on that edge, so a full 20-step sequence with defaults takes about 20×(8+3) cycles.
- `CS_n` is high for at least 2 cycles between consecutive bus cycles.

## Test plan
- **Reset values:** assert reset mid-STROBE of step 3 → `CS_n=WR_n=1`, `ad_oe=0` within the same cycle; no `Final_WR`; after release with `ctrl_L=3`, a new cycle launches.
- **Address write:** `ctrl_L` 0→1 → `CS_n` low at edge 0, `WR_n` low edges 2..5, `ad_out=8'h21`, `A_D=0`, `ad_oe=1` through HOLD, `Final_WR` high at edge 8 only.
- **Data read:** `ctrl_L=2`, `ad_in=8'h37` during STROBE → `RD_n` low 4 cycles; at `Final_WR`, `dato_leido=8'h37`, `reg_idx=0`, `dato_valido=1`.
- **Last pair:** `ctrl_L=19` then 20 → `ad_out=8'h2A`; the read returns `reg_idx=9`. `ctrl_L=21` then 0 → no bus activity; `CS_n` stays high.
- **Closed loop with the read FSM:** pulse `Inicio_L` → exactly 20 `Final_WR` pulses and 10 `dato_valido` pulses with `reg_idx` 0..9 in order; the FSM returns to index 0.
- **Mid-cycle index change:** `ctrl_L` changes 1→2 during the HOLD of step 1 → no glitch; step 2 launches on the first IDLE edge after FIN.
